md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Holds the architectural HI/LO registers and serves MFHI/MFLO reads.
- Exports busy/active indications that the hazard unit turns into the stall signal driving the ID/EX pipeline registers.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  op is valid this cycle (E-stage holds an MD instruction)
- op  in  4  operation code from md_pkg: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, others NONE
- a  in  32  rs operand (forwarded)
- b  in  32  rt operand (forwarded)
- cancel  in  1  E-stage instruction is squashed by an exception/interrupt this cycle
- busy  out  1  long operation in progress (registered)
- active  out  1  comb: busy | (start & op is MULT/MULTU/DIV/DIVU & ~cancel)
- hi  out  32  architectural HI (registered)
- lo  out  32  architectural LO (registered)

Behaviour:
- Reset (reset==0, asynchronous): busy=0, hi=0, lo=0, counter=0, pending result cleared. Reset during a busy operation aborts it; HI/LO stay 0.
- An op is accepted at a rising edge only if start=1, cancel=0 and busy=0.
- When busy=1, start is ignored. The hazard unit guarantees this never happens.
- cancel has no effect on an operation already accepted.
- MTHI/MTLO: at the accepting edge, hi<=a (MTHI) or lo<=a (MTLO). busy stays 0. No latency; visible the cycle after.
- Long ops: at the accepting edge, compute the 64-bit result from a/b and latch it into an internal pending register. Set busy=1 and counter=N-1, where N=MULT_CYCLES or DIV_CYCLES.
  - Each subsequent edge with busy=1 and counter!=0 decrements counter.
  - At the edge where busy=1 and counter==0: hi/lo <= pending, busy<=0.
  - busy is therefore high for exactly N cycles. The new hi/lo is visible in the cycle after busy falls.
- MULT: signed 32x32 -> 64; hi=bits[63:32], lo=bits[31:0].
- MULTU: same, unsigned.
- DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend a.
- DIVU: unsigned quotient/remainder.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b==0, DIV or DIVU): full DIV_CYCLES busy period runs; hi/lo are NOT updated at completion.
- MFHI/MFLO are served combinationally from hi/lo. The hazard unit stalls MFHI/MFLO/MD ops in ID while active=1.
- Back-to-back ops: a new long op or MTHI/MTLO may be accepted in the same cycle that busy=0 follows completion. There is no dead cycle.
- op NONE or undefined with start=1: no state change.

Decomposition:
- md_pkg: op code constants (MD_NONE..MD_MTLO, 4-bit), default cycle counts.
- Sub-module md_calc: purely combinational. Inputs op, a, b. Outputs result[63:0] and div_by_zero. Isolates signed/unsigned product and quotient/remainder arithmetic.
- md_unit holds the counter, busy, pending register and HI/LO.

Test Plan:
- Reset mid-MULT: start MULT a=3 b=4, drop reset after 2 cycles -> busy=0, hi=0, lo=0 immediately (asynchronous), no later update.
- MULT a=0xFFFFFFFE b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1.
- DIVU a=5 b=0 after MTHI 0x1234 and MTLO 0x5678 -> busy 10 cycles; hi=0x1234 and lo=0x5678 unchanged.
- start MULT with cancel=1 -> busy and active stay 0, hi/lo unchanged. start MTLO a=9 with cancel=1 -> lo unchanged.
- During MULT busy, pulse start DIV -> ignored, MULT result written. Start DIV in the cycle after busy falls -> accepted, busy 10 cycles.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes and default latencies.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for several cycles and raise busy.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational arithmetic core: signed/unsigned 32x32 product and quotient/remainder.
module md_calc
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;

    logic [31:0] b_safe;
    logic [31:0] uq;
    logic [31:0] ur;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_b_safe;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic [31:0] sq;
    logic [31:0] sr;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Zero divisors are replaced by 1 so the dividers never see 0; the result is discarded anyway.
    assign b_safe = (b == 32'd0) ? 32'd1 : b;
    assign uq     = a / b_safe;
    assign ur     = a % b_safe;

    // Signed divide on magnitudes: quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    assign mag_a      = a[31] ? (32'd0 - a) : a;
    assign mag_b      = b[31] ? (32'd0 - b) : b;
    assign mag_b_safe = (b == 32'd0) ? 32'd1 : mag_b;
    assign sq_mag     = mag_a / mag_b_safe;
    assign sr_mag     = mag_a % mag_b_safe;
    assign sq         = (a[31] ^ b[31]) ? (32'd0 - sq_mag) : sq_mag;
    assign sr         = a[31] ? (32'd0 - sr_mag) : sr_mag;

    always_comb begin
        result      = 64'd0;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = {sr, sq};
            MD_DIVU:  result = {ur, uq};
            default:  result = 64'd0;
        endcase
        if (is_div_op(op) && (b == 32'd0)) begin
            div_by_zero = 1'b1;
        end
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, runs long ops for a fixed latency, reports busy/active.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        active,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

    logic [3:0]  count;
    logic [63:0] pending;
    logic        pending_wr;

    logic [63:0] calc_result;
    logic        calc_div_by_zero;
    logic        accept;

    md_calc u_calc (
        .op          (op),
        .a           (a),
        .b           (b),
        .result      (calc_result),
        .div_by_zero (calc_div_by_zero)
    );

    assign accept = start & ~cancel & ~busy;
    assign active = busy | (start & is_long_op(op) & ~cancel);

    // While busy, the countdown owns the unit and start is deliberately ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            count      <= 4'd0;
            pending    <= 64'd0;
            pending_wr <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else if (busy) begin
            if (count != 4'd0) begin
                count <= count - 4'd1;
            end else begin
                busy <= 1'b0;
                if (pending_wr) begin
                    hi <= pending[63:32];
                    lo <= pending[31:0];
                end
            end
        end else if (accept) begin
            case (op)
                MD_MTHI: hi <= a;
                MD_MTLO: lo <= a;
                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                    pending    <= calc_result;
                    pending_wr <= ~calc_div_by_zero;
                    busy       <= 1'b1;
                    count      <= is_div_op(op) ? DIV_LAST : MULT_LAST;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, multi-cycle corner sequences, randomized ops vs. a model.
module tb_md_unit;
    import md_pkg::*;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        active;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests;
    int n_fail;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [3:0]  t_op;
        logic [31:0] t_a;
        logic [31:0] t_b;
        logic        t_cancel;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[14];

    md_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .active (active),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural effect of one op computed from plain arithmetic.
    task automatic model_apply(input logic [3:0] t_op, input logic [31:0] ta, input logic [31:0] tb_v,
                               input logic t_cancel, output int cyc);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        int              qi, ri;
        cyc = 0;
        if (t_cancel) return;
        case (t_op)
            MD_MULT: begin
                sa = $signed(ta); sb = $signed(tb_v); sp = sa * sb;
                m_hi = sp[63:32]; m_lo = sp[31:0]; cyc = N_MULT;
            end
            MD_MULTU: begin
                ua = {32'd0, ta}; ub = {32'd0, tb_v}; up = ua * ub;
                m_hi = up[63:32]; m_lo = up[31:0]; cyc = N_MULT;
            end
            MD_DIV: begin
                cyc = N_DIV;
                if (tb_v != 0) begin
                    if (ta == 32'h8000_0000 && tb_v == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000; m_hi = 32'd0;
                    end else begin
                        qi = $signed(ta) / $signed(tb_v);
                        ri = $signed(ta) % $signed(tb_v);
                        m_lo = qi; m_hi = ri;
                    end
                end
            end
            MD_DIVU: begin
                cyc = N_DIV;
                if (tb_v != 0) begin
                    m_lo = ta / tb_v; m_hi = ta % tb_v;
                end
            end
            MD_MTHI: m_hi = ta;
            MD_MTLO: m_lo = ta;
            default: ;
        endcase
    endtask

    // Issue one op for a single cycle, then count busy cycles (bounded) until it drops.
    task automatic do_op(input logic [3:0] t_op, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic t_cancel, output int cycles);
        logic exp_active;
        @(negedge clk);
        start = 1'b1; op = t_op; a = ta; b = tb_v; cancel = t_cancel;
        exp_active = (t_op >= 4'd1) && (t_op <= 4'd4) && !t_cancel;
        #1;
        check("active_on_issue", {31'd0, active}, {31'd0, exp_active});
        @(posedge clk);
        #1;
        start = 1'b0; op = MD_NONE; cancel = 1'b0;
        @(negedge clk);
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int exp_cyc;
        logic [3:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic        r_cancel;

        n_tests = 0;
        n_fail  = 0;
        m_hi = 0;
        m_lo = 0;
        reset = 1'b0; start = 1'b0; op = MD_NONE; a = 0; b = 0; cancel = 1'b0;

        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, N_MULT};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFE, 32'd3,        1'b0, 32'h0000_0002, 32'hFFFF_FFFA, N_MULT};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, N_DIV};
        vecs[3]  = '{MD_DIVU,  32'd7,         32'd2,        1'b0, 32'd1,         32'd3,         N_DIV};
        vecs[4]  = '{MD_MTHI,  32'h1234,      32'd0,        1'b0, 32'h1234,      32'd3,         0};
        vecs[5]  = '{MD_MTLO,  32'h5678,      32'd0,        1'b0, 32'h1234,      32'h5678,      0};
        vecs[6]  = '{MD_DIVU,  32'd5,         32'd0,        1'b0, 32'h1234,      32'h5678,      N_DIV};
        vecs[7]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,        32'h8000_0000, N_DIV};
        vecs[8]  = '{MD_NONE,  32'hAB,        32'hCD,       1'b0, 32'd0,         32'h8000_0000, 0};
        vecs[9]  = '{4'd9,     32'hAB,        32'hCD,       1'b0, 32'd0,         32'h8000_0000, 0};
        vecs[10] = '{MD_DIV,   32'd5,         32'd0,        1'b0, 32'd0,         32'h8000_0000, N_DIV};
        vecs[11] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 1'b0, 32'd1,        32'hFFFF_FFFD, N_DIV};
        vecs[12] = '{MD_MULT,  32'd3,         32'd4,        1'b1, 32'd1,         32'hFFFF_FFFD, 0};
        vecs[13] = '{MD_MTLO,  32'd9,         32'd0,        1'b1, 32'd1,         32'hFFFF_FFFD, 0};

        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_active", {31'd0, active}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            model_apply(vecs[i].t_op, vecs[i].t_a, vecs[i].t_b, vecs[i].t_cancel, exp_cyc);
            do_op(vecs[i].t_op, vecs[i].t_a, vecs[i].t_b, vecs[i].t_cancel, cyc);
            check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cycles);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // Start held high through a MULT: ignored while busy, accepted on the first idle edge.
        @(negedge clk);
        start = 1'b1; op = MD_MULT; a = 32'd6; b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        op = MD_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("b2b_mult_cycles", cyc, N_MULT);
        check("b2b_mult_hi", hi, 32'hFFFF_FFFF);
        check("b2b_mult_lo", lo, 32'hFFFF_FFFA);
        check("b2b_active_idle", {31'd0, active}, 32'd1);
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("b2b_div_cycles", cyc, N_DIV);
        check("b2b_div_hi", hi, 32'd2);
        check("b2b_div_lo", lo, 32'd14);
        m_hi = 32'd2;
        m_lo = 32'd14;

        for (int i = 0; i < 60; i++) begin
            r_op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) r_op = 4'($urandom_range(1, 6));
            r_a = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: r_b = 32'($urandom_range(1, 20));
                2: r_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: r_b = $urandom;
            endcase
            r_cancel = ($urandom_range(0, 9) == 0);
            model_apply(r_op, r_a, r_b, r_cancel, exp_cyc);
            do_op(r_op, r_a, r_b, r_cancel, cyc);
            check($sformatf("rnd%0d_op%0d_cycles", i, r_op), cyc, exp_cyc);
            check($sformatf("rnd%0d_op%0d_hi", i, r_op), hi, m_hi);
            check($sformatf("rnd%0d_op%0d_lo", i, r_op), lo, m_lo);
        end

        // Asynchronous reset in the middle of a MULT aborts it.
        @(negedge clk);
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0; op = MD_NONE;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_after_busy", {31'd0, busy}, 32'd0);
        check("rst_after_hi", hi, 32'd0);
        check("rst_after_lo", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
